// File: rtl/wb_tester_pkg.sv
// Shared types and constants for the Wishbone burst memory tester.
// Holds the FSM encoding, pattern mode codes and LFSR tap masks.
package wb_tester_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_BURST   = 3'd1,
    GAP        = 3'd2,
    READ_SEED  = 3'd3,
    READ_BURST = 3'd4,
    FINISH     = 3'd5
  } state_t;

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_NADDR = 2'd3;

  localparam logic [2:0] CTI_INCR   = 3'b010;
  localparam logic [2:0] CTI_END    = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_24 = 64'h0000_0000_00E1_0000;
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

  // Galois right-shift masks; other widths reuse the 32-bit mask.
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] t;
    t = TAPS_32;
    if (w == 8)  t = TAPS_8;
    if (w == 16) t = TAPS_16;
    if (w == 24) t = TAPS_24;
    if (w == 64) t = TAPS_64;
    return t;
  endfunction

endpackage

// File: rtl/wb_burst_mem_tester_pattern.sv
// Test-pattern source: address, inverted address, LFSR or walking one.
// Owns the LFSR and walking-one state; load restarts the sequence.
module wb_pattern_gen
  import wb_tester_pkg::*;
#(
  parameter int          ADR_WIDTH  = 30,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADR_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0] word
);

  localparam logic [DATA_WIDTH-1:0] TAPS =
    DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] seed;
  logic [DATA_WIDTH-1:0] lfsr;
  logic [DATA_WIDTH-1:0] walk;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_seed
    assign seed[i] = LFSR_SEED[i % 32];
  end

  always_ff @(posedge clock) begin
    if (reset || load) begin
      lfsr <= seed;
      walk <= DATA_WIDTH'(1);
    end else if (step) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
      walk <= {walk[DATA_WIDTH-2:0], walk[DATA_WIDTH-1]};
    end
  end

  always_comb begin
    word = '0;
    unique case (mode)
      MODE_ADDR:  word = DATA_WIDTH'(address);
      MODE_LFSR:  word = lfsr;
      MODE_WALK:  word = walk;
      MODE_NADDR: word = ~DATA_WIDTH'(address);
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/wb_burst_mem_tester.sv
// Wishbone burst master that fills a memory region with a pattern,
// reads it back and reports mismatches.
module wb_burst_mem_tester
  import wb_tester_pkg::*;
#(
  parameter int          ADR_WIDTH  = 30,
  parameter int          DATA_WIDTH = 32,
  parameter int          BURST_LEN  = 8,
  parameter int          LEN_WIDTH  = 16,
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADR_WIDTH-1:0]    base_adr,
  input  logic [LEN_WIDTH-1:0]    length,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [LEN_WIDTH-1:0]    error_count,
  output logic [ADR_WIDTH-1:0]    first_err_adr,
  output logic [DATA_WIDTH-1:0]   first_err_exp,
  output logic [DATA_WIDTH-1:0]   first_err_got,
  output logic [ADR_WIDTH-1:0]    wishbone_adr,
  output logic [DATA_WIDTH-1:0]   wishbone_dat_w,
  input  logic [DATA_WIDTH-1:0]   wishbone_dat_r,
  output logic [DATA_WIDTH/8-1:0] wishbone_sel,
  output logic                    wishbone_cyc,
  output logic                    wishbone_stb,
  input  logic                    wishbone_ack,
  output logic                    wishbone_we,
  output logic [2:0]              wishbone_cti,
  output logic [1:0]              wishbone_bte,
  input  logic                    wishbone_err
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state;
  logic [ADR_WIDTH-1:0]  adr;
  logic [ADR_WIDTH-1:0]  base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  rem;
  logic [BW-1:0]         beats;
  logic [TW-1:0]         tmo;
  logic [1:0]            mode_q;
  logic                  rd_phase;
  logic                  gen_load;
  logic                  gen_step;
  logic                  last_beat;
  logic                  timed_out;
  logic                  miss;
  logic [DATA_WIDTH-1:0] word;

  // Beats to the next aligned boundary also keep bursts off the wrap.
  function automatic logic [BW-1:0] burst_beats(
    input logic [ADR_WIDTH-1:0] a,
    input logic [LEN_WIDTH-1:0] r
  );
    logic [31:0] n;
    logic [31:0] b;
    b = 32'(BURST_LEN) - 32'(a & ADR_WIDTH'(BURST_LEN - 1));
    n = 32'(r);
    if (b < n) n = b;
    return BW'(n);
  endfunction

  wb_pattern_gen #(
    .ADR_WIDTH (ADR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clock  (clock),
    .reset  (reset),
    .mode   (mode_q),
    .load   (gen_load),
    .step   (gen_step),
    .address(adr),
    .word   (word)
  );

  assign last_beat = beats == BW'(1);
  assign timed_out = !wishbone_ack && tmo == TW'(TIMEOUT - 1);
  assign miss      = wishbone_dat_r != word;
  assign gen_load  = (state == IDLE && start) || state == READ_SEED;
  assign gen_step  = wishbone_stb && wishbone_ack && !wishbone_err;

  assign wishbone_adr   = adr;
  assign wishbone_dat_w = wishbone_we ? word : '0;
  assign wishbone_sel   = '1;
  assign wishbone_bte   = BTE_LINEAR;
  assign wishbone_cti   = !wishbone_stb ? 3'b000 :
                          last_beat ? CTI_END : CTI_INCR;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      adr           <= '0;
      base_q        <= '0;
      len_q         <= '0;
      rem           <= '0;
      beats         <= '0;
      tmo           <= '0;
      mode_q        <= MODE_ADDR;
      rd_phase      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      error_count   <= '0;
      first_err_adr <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      wishbone_cyc  <= 1'b0;
      wishbone_stb  <= 1'b0;
      wishbone_we   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q        <= base_adr;
            len_q         <= length;
            mode_q        <= mode;
            adr           <= base_adr;
            rem           <= length;
            beats         <= burst_beats(base_adr, length);
            tmo           <= '0;
            rd_phase      <= 1'b0;
            aborted       <= 1'b0;
            error_count   <= '0;
            first_err_adr <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            if (length == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              busy         <= 1'b1;
              wishbone_cyc <= 1'b1;
              wishbone_stb <= 1'b1;
              wishbone_we  <= 1'b1;
              state        <= WR_BURST;
            end
          end
        end
        WR_BURST, READ_BURST: begin
          if (wishbone_err || timed_out) begin
            wishbone_cyc <= 1'b0;
            wishbone_stb <= 1'b0;
            wishbone_we  <= 1'b0;
            aborted      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= FINISH;
          end else if (wishbone_ack) begin
            adr   <= adr + ADR_WIDTH'(1);
            rem   <= rem - LEN_WIDTH'(1);
            beats <= beats - BW'(1);
            tmo   <= '0;
            if (!wishbone_we && miss) begin
              if (error_count != '1)
                error_count <= error_count + LEN_WIDTH'(1);
              if (error_count == '0) begin
                first_err_adr <= adr;
                first_err_exp <= word;
                first_err_got <= wishbone_dat_r;
              end
            end
            if (last_beat) begin
              wishbone_cyc <= 1'b0;
              wishbone_stb <= 1'b0;
              wishbone_we  <= 1'b0;
              // Final read beat skips the gap and completes directly.
              if (rd_phase && rem == LEN_WIDTH'(1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                state <= GAP;
              end
            end
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        GAP: begin
          tmo   <= '0;
          beats <= burst_beats(adr, rem);
          if (rd_phase) begin
            wishbone_cyc <= 1'b1;
            wishbone_stb <= 1'b1;
            state        <= READ_BURST;
          end else if (rem != '0) begin
            wishbone_cyc <= 1'b1;
            wishbone_stb <= 1'b1;
            wishbone_we  <= 1'b1;
            state        <= WR_BURST;
          end else begin
            state <= READ_SEED;
          end
        end
        READ_SEED: begin
          adr          <= base_q;
          rem          <= len_q;
          beats        <= burst_beats(base_q, len_q);
          tmo          <= '0;
          rd_phase     <= 1'b1;
          wishbone_cyc <= 1'b1;
          wishbone_stb <= 1'b1;
          wishbone_we  <= 1'b0;
          state        <= READ_BURST;
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
